// File: rtl/connect_four_pkg.sv
// Shared constants and types for the Connect Four pushbutton front end.
package connect_four_pkg;

    localparam int unsigned BTN_DROP  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_LEFT  = 2;

    // Default timing at 25 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEF_REPEAT_DELAY    = 12500000;
    localparam int unsigned DEF_REPEAT_RATE     = 5000000;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rpt_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stability filter and registered press-edge strobe.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk_25MHz,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample matching the stable level restarts the count
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= btn;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            press_q      <= stable_q & ~stable_dly_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/connect_four_input_ctrl.sv
// Player button conditioning: debounced press strobes, left/right auto-repeat and conflict lockout.
module connect_four_input_ctrl
    import connect_four_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       btn_drop,
    input  logic       btn_right,
    input  logic       btn_left,
    output logic       drop_piece,
    output logic       move_right,
    output logic       move_left,
    output logic [2:0] btn_level
);

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RW   = $clog2(RMAX);

    logic [2:0] raw;
    logic [2:0] level;
    logic [2:0] press;
    logic       conflict;
    logic       conflict_q;
    logic [1:0] dir_level;
    logic [1:0] dir_press;
    logic [1:0] dir_move;

    assign raw[BTN_DROP]  = btn_drop;
    assign raw[BTN_RIGHT] = btn_right;
    assign raw[BTN_LEFT]  = btn_left;

    for (genvar b = 0; b < 3; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk_25MHz(clk_25MHz),
            .rst_n    (rst_n),
            .btn      (raw[b]),
            .level    (level[b]),
            .press    (press[b])
        );
    end

    assign conflict  = level[BTN_LEFT] & level[BTN_RIGHT];
    assign dir_level = {level[BTN_LEFT], level[BTN_RIGHT]};
    assign dir_press = {press[BTN_LEFT], press[BTN_RIGHT]};

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict;
        end
    end

    // Index 0 = right, 1 = left
    for (genvar d = 0; d < 2; d++) begin : g_rpt
        rpt_state_e    state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          rpt_strobe;

        always_comb begin
            state_d    = state_q;
            rcnt_d     = rcnt_q;
            rpt_strobe = 1'b0;
            if (!dir_level[d] || conflict) begin
                state_d = StIdle;
                rcnt_d  = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // conflict_q here means the opposite button was just released
                        if (dir_press[d] || conflict_q) begin
                            state_d = StDelay;
                            rcnt_d  = '0;
                        end
                    end
                    StDelay: begin
                        if (rcnt_q == RW'(REPEAT_DELAY - 1)) begin
                            rpt_strobe = 1'b1;
                            state_d    = StRepeat;
                            rcnt_d     = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                    StRepeat: begin
                        if (rcnt_q == RW'(REPEAT_RATE - 1)) begin
                            rpt_strobe = 1'b1;
                            rcnt_d     = '0;
                        end else begin
                            rcnt_d = rcnt_q + RW'(1);
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_25MHz or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                rcnt_q  <= '0;
            end else begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
            end
        end

        assign dir_move[d] = ~conflict & (dir_press[d] | rpt_strobe);
    end

    assign drop_piece = press[BTN_DROP];
    assign move_right = dir_move[0];
    assign move_left  = dir_move[1];
    assign btn_level  = level;

endmodule

// File: tb/tb_connect_four_input_ctrl.sv
// Bench for connect_four_input_ctrl: directed scenarios plus random stimulus against a window model.
module tb_connect_four_input_ctrl;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_drop = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_left = 1'b0;
    logic       drop_piece, move_right, move_left;
    logic [2:0] btn_level;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    connect_four_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk_25MHz (clk),
        .rst_n     (rst_n),
        .btn_drop  (btn_drop),
        .btn_right (btn_right),
        .btn_left  (btn_left),
        .drop_piece(drop_piece),
        .move_right(move_right),
        .move_left (move_left),
        .btn_level (btn_level)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a level is accepted once the last D synchronised samples all differ from it;
    // repeats are timed by the age of the press (or conflict-release) anchor.
    logic [7:0] hist [3];
    logic [2:0] st = '0, st_prev = '0, pr = '0;
    logic [1:0] valid = '0, mv = '0;
    int         age [2];
    logic       conf_prev = 1'b0;
    logic [5:0] exp_vec = '0;

    always @(posedge clk or negedge rst_n) begin
        logic [2:0] raw;
        logic       agree, conf, rep;
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) hist[b] = '0;
            st = '0; st_prev = '0; pr = '0;
            valid = '0; mv = '0; conf_prev = 1'b0; exp_vec = '0;
            age[0] = 0; age[1] = 0;
        end else begin
            raw = {btn_left, btn_right, btn_drop};
            for (int b = 0; b < 3; b++) begin
                hist[b] = {hist[b][6:0], raw[b]};
                pr[b] = st[b] & ~st_prev[b];
                st_prev[b] = st[b];
                agree = 1'b1;
                for (int k = 2; k <= D + 1; k++) if (hist[b][k] == st[b]) agree = 1'b0;
                if (agree) st[b] = ~st[b];
            end
            conf = st[2] & st[1];
            for (int d = 0; d < 2; d++) begin
                if (!st[d+1] || conf) begin
                    valid[d] = 1'b0;
                end else if (!valid[d] && (pr[d+1] || conf_prev)) begin
                    valid[d] = 1'b1;
                    age[d] = 0;
                end else if (valid[d]) begin
                    age[d]++;
                end
                rep = valid[d] && age[d] >= RD && ((age[d] - RD) % RR) == 0;
                mv[d] = !conf && (pr[d+1] || rep);
            end
            conf_prev = conf;
            exp_vec = {pr[0], mv[0], mv[1], st};
        end
    end

    always @(negedge clk) begin
        check("outputs{drop,right,left,level}",
              int'({drop_piece, move_right, move_left, btn_level}), int'(exp_vec));
    end

    // Strobe tallies for the directed scenarios: index 0 drop, 1 right, 2 left
    int rel = 0;
    int cnt [3];
    int first [3];
    int last [3];

    task automatic clear_tally();
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0; first[i] = -1; last[i] = -1;
        end
    endtask

    task automatic run(input int n);
        logic [2:0] s;
        repeat (n) begin
            @(posedge clk);
            rel++;
            @(negedge clk);
            s = {move_left, move_right, drop_piece};
            for (int i = 0; i < 3; i++) begin
                if (s[i]) begin
                    if (cnt[i] == 0) first[i] = rel;
                    last[i] = rel;
                    cnt[i]++;
                end
            end
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs_zero", int'({drop_piece, move_right, move_left, btn_level}), 0);
        repeat (n) @(negedge clk);
        rst_n = 1'b1;
        rel = 0;
    endtask

    initial begin
        int hold [3];
        logic [2:0] rv;
        repeat (2) @(negedge clk);
        check("initial_reset_outputs", int'({drop_piece, move_right, move_left, btn_level}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean drop press
        clear_tally(); rel = 0; btn_drop = 1'b1;
        run(50);
        check("drop_count", cnt[0], 1);
        check("drop_first", first[0], 7);
        btn_drop = 1'b0;
        run(15);

        // Bouncing right, then steady
        clear_tally();
        for (int i = 0; i < 4; i++) begin
            btn_right = ~i[0];
            run(2);
        end
        check("bounce_no_strobe", cnt[1], 0);
        clear_tally(); rel = 0; btn_right = 1'b1;
        run(20);
        check("bounce_right_count", cnt[1], 1);
        check("bounce_right_first", first[1], 7);
        btn_right = 1'b0;
        run(15);

        // Left held: press then auto-repeat
        clear_tally(); rel = 0; btn_left = 1'b1;
        run(60);
        check("left_first", first[2], 7);
        check("left_count", cnt[2], 6);
        check("left_last", last[2], 59);
        clear_tally(); btn_left = 1'b0;
        run(30);
        check("left_release_quiet", cnt[2], 0);

        // Right held, left joins, left released
        clear_tally(); rel = 0; btn_right = 1'b1;
        run(10);
        check("conf_right_press", first[1], 7);
        clear_tally(); btn_left = 1'b1;
        run(30);
        check("conf_window_right", cnt[1], 0);
        check("conf_window_left", cnt[2], 0);
        clear_tally(); btn_left = 1'b0;
        run(40);
        check("conf_after_right_first", first[1], 66);
        check("conf_after_left", cnt[2], 0);
        btn_right = 1'b0;
        run(15);

        // Reset mid-repeat with left held
        clear_tally(); rel = 0; btn_left = 1'b1;
        run(30);
        check("pre_reset_left_count", cnt[2], 2);
        do_reset(3);
        clear_tally();
        run(40);
        check("post_reset_left_first", first[2], 7);
        check("post_reset_left_count", cnt[2], 3);
        btn_left = 1'b0;
        run(15);

        // All three at once
        clear_tally(); rel = 0;
        btn_drop = 1'b1; btn_right = 1'b1; btn_left = 1'b1;
        run(40);
        check("all_drop_count", cnt[0], 1);
        check("all_drop_first", first[0], 7);
        check("all_right_count", cnt[1], 0);
        check("all_left_count", cnt[2], 0);
        btn_drop = 1'b0; btn_right = 1'b0; btn_left = 1'b0;
        run(15);

        // Random holds and bounces, occasional reset
        for (int i = 0; i < 3; i++) hold[i] = 0;
        rv = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (hold[i] == 0) begin
                    rv[i] = 1'($urandom_range(0, 1));
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                          : $urandom_range(5, 45);
                end else begin
                    hold[i]--;
                end
            end
            btn_drop = rv[0]; btn_right = rv[1]; btn_left = rv[2];
            if ($urandom_range(0, 799) == 0) begin
                do_reset($urandom_range(1, 4));
            end else begin
                run(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
